// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   - arb_state_e : arbitration FSM state; names the owner of the previous cycle
//   - arb_port_e  : which master owns the memory port this cycle
//   - F3_*        : load/store size codes carried on the funct3 lines
//   - WAIT_CNT_W  : width of the DMA starvation counter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CORE       = 2'd1,
    ST_DMA        = 2'd2,
    ST_DMA_LOCKED = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DMA  = 1'b1
  } arb_port_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the core request port, the DMA request port and the data-memory
//   port of the arbiter.
//   - slave  : arbiter view (takes requests and mem_rd, drives grants/mem_*)
//   - master : environment view (drives requests and mem_rd)
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  // core (MEM stage) port
  logic                  core_req;
  logic                  core_we;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_funct3;
  logic                  core_gnt;
  logic                  core_stall;
  logic                  core_rvalid;
  logic [DATA_W-1:0]     core_rdata;

  // DMA / loader port
  logic                  dma_req;
  logic                  dma_we;
  logic [DM_ADDRESS-1:0] dma_addr;
  logic [DATA_W-1:0]     dma_wdata;
  logic [2:0]            dma_funct3;
  logic                  dma_lock;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_W-1:0]     dma_rdata;

  // data memory port
  logic                  mem_read;
  logic                  mem_write;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rd;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_funct3,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_funct3, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_read, mem_write, mem_a, mem_wd, mem_funct3,
    input  mem_rd
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_funct3,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_funct3, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_read, mem_write, mem_a, mem_wd, mem_funct3,
    output mem_rd
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt
//   Saturating wait counter counting consecutive cycles the DMA port has
//   requested without being granted.
//   Ports:
//     clk      in   clock
//     reset    in   synchronous active-high reset (clears the count)
//     i_inc    in   DMA requested and lost this cycle
//     i_clr    in   DMA granted, or not requesting
//     o_at_max out  count has reached MAX_WAIT
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the pipeline MEM stage (core)
//   and a DMA/loader port. One access is granted per cycle; the loser is
//   stalled. Load data is registered so both masters see a one-cycle latency.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-high reset
//     bus    slave modport of dmem_arbiter_if:
//              core_* / dma_* request bundles in, gnt/stall/rvalid/rdata out,
//              mem_read/mem_write/mem_a/mem_wd/mem_funct3 out, mem_rd in
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  arb_port_e         w_owner;
  logic              w_core_gnt;
  logic              w_dma_gnt;
  logic              w_any_gnt;
  logic              w_sel_we;
  logic              w_at_max;
  logic              r_core_rvalid;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  dmem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (bus.dma_req & ~w_dma_gnt),
    .i_clr    (w_dma_gnt | ~bus.dma_req),
    .o_at_max (w_at_max)
  );

  // Grant decision, next state and memory mux.
  always_comb begin
    w_core_gnt   = 1'b0;
    w_dma_gnt    = 1'b0;
    w_state_next = ST_IDLE;

    // No access is issued while reset is held, so an in-flight store can
    // never reach the memory during the reset cycle.
    if (reset) begin
      w_core_gnt = 1'b0;
    end else if ((r_state == ST_DMA_LOCKED) && bus.dma_req && bus.dma_lock) begin
      w_dma_gnt = 1'b1;
    end else if (bus.dma_req && w_at_max) begin
      w_dma_gnt = 1'b1;
    end else if (bus.core_req) begin
      w_core_gnt = 1'b1;
    end else if (bus.dma_req) begin
      w_dma_gnt = 1'b1;
    end

    if (w_core_gnt) begin
      w_state_next = ST_CORE;
    end else if (w_dma_gnt) begin
      w_state_next = bus.dma_lock ? ST_DMA_LOCKED : ST_DMA;
    end

    w_owner   = w_dma_gnt ? PORT_DMA : PORT_CORE;
    w_any_gnt = w_core_gnt | w_dma_gnt;
    w_sel_we  = (w_owner == PORT_DMA) ? bus.dma_we : bus.core_we;

    bus.mem_read   = w_any_gnt & ~w_sel_we;
    bus.mem_write  = w_any_gnt &  w_sel_we;
    bus.mem_a      = '0;
    bus.mem_wd     = '0;
    bus.mem_funct3 = '0;
    if (w_any_gnt) begin
      if (w_owner == PORT_DMA) begin
        bus.mem_a      = bus.dma_addr;
        bus.mem_wd     = bus.dma_wdata;
        bus.mem_funct3 = bus.dma_funct3;
      end else begin
        bus.mem_a      = bus.core_addr;
        bus.mem_wd     = bus.core_wdata;
        bus.mem_funct3 = bus.core_funct3;
      end
    end
  end

  // State and read-return registers. rdata is only updated by a load of the
  // same port, so it holds across stores, idle cycles and the other port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_core_rvalid <= 1'b0;
      r_dma_rvalid  <= 1'b0;
      r_core_rdata  <= '0;
      r_dma_rdata   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_core_rvalid <= w_core_gnt & ~bus.core_we;
      r_dma_rvalid  <= w_dma_gnt & ~bus.dma_we;
      if (w_core_gnt && !bus.core_we) begin
        r_core_rdata <= bus.mem_rd;
      end
      if (w_dma_gnt && !bus.dma_we) begin
        r_dma_rdata <= bus.mem_rd;
      end
    end
  end

  assign bus.core_gnt    = w_core_gnt;
  assign bus.dma_gnt     = w_dma_gnt;
  assign bus.core_stall  = bus.core_req & ~w_core_gnt;
  // A load return pending when reset rises is dropped immediately.
  assign bus.core_rvalid = r_core_rvalid & ~reset;
  assign bus.dma_rvalid  = r_dma_rvalid & ~reset;
  assign bus.core_rdata  = r_core_rdata;
  assign bus.dma_rdata   = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .DM_ADDRESS (9),
    .DATA_W     (32),
    .MAX_WAIT   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.core_req    = 1'b0;
    bus.core_we     = 1'b0;
    bus.core_addr   = '0;
    bus.core_wdata  = '0;
    bus.core_funct3 = '0;
    bus.dma_req     = 1'b0;
    bus.dma_we      = 1'b0;
    bus.dma_addr    = '0;
    bus.dma_wdata   = '0;
    bus.dma_funct3  = '0;
    bus.dma_lock    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d;
    logic prev_d;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle_reqs();
    bus.mem_rd = '0;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    #4;
    $display("txn reset: checking reset values");
    chk("rst_core_rvalid", bus.core_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rst_core_rdata", bus.core_rdata, 0);
    chk("rst_dma_rdata", bus.dma_rdata, 0);
    chk("rst_core_gnt", bus.core_gnt, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_state", dut.r_state, ST_IDLE);
    chk("rst_wait_cnt", dut.u_starve.r_cnt, 0);
    tick();

    // ---- core LW 0x010 alone ----
    $display("txn core LW addr=010");
    bus.core_req    = 1'b1;
    bus.core_we     = 1'b0;
    bus.core_addr   = 9'h010;
    bus.core_funct3 = F3_LW;
    bus.mem_rd      = 32'h11223344;
    #4;
    chk("lw_core_gnt", bus.core_gnt, 1);
    chk("lw_mem_read", bus.mem_read, 1);
    chk("lw_mem_write", bus.mem_write, 0);
    chk("lw_mem_a", bus.mem_a, 32'h010);
    chk("lw_mem_funct3", bus.mem_funct3, 32'h2);
    chk("lw_core_stall", bus.core_stall, 0);
    chk("lw_rvalid_early", bus.core_rvalid, 0);
    tick();
    idle_reqs();
    bus.mem_rd = 32'hFFFF0000;
    #4;
    chk("lw_core_rvalid", bus.core_rvalid, 1);
    chk("lw_core_rdata", bus.core_rdata, 32'h11223344);
    chk("lw_dma_rvalid", bus.dma_rvalid, 0);
    tick();
    #4;
    chk("lw_rvalid_pulse", bus.core_rvalid, 0);
    tick();

    // ---- both request every cycle: core x4, DMA on the 5th ----
    prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.core_req    = 1'b1;
      bus.core_we     = 1'b0;
      bus.core_addr   = 9'h100;
      bus.core_funct3 = F3_LW;
      bus.dma_req     = 1'b1;
      bus.dma_we      = 1'b0;
      bus.dma_addr    = 9'h080;
      bus.dma_funct3  = F3_LW;
      bus.mem_rd      = 32'hA0000000 + 32'(i);
      #4;
      exp_d = ((i % 5) == 4);
      $display("txn contend cycle %0d: expect %s", i, exp_d ? "dma" : "core");
      chk("ct_core_gnt", bus.core_gnt, {31'b0, ~exp_d});
      chk("ct_dma_gnt", bus.dma_gnt, {31'b0, exp_d});
      chk("ct_core_stall", bus.core_stall, {31'b0, exp_d});
      chk("ct_mem_a", bus.mem_a, exp_d ? 32'h080 : 32'h100);
      chk("ct_dma_rvalid", bus.dma_rvalid, {31'b0, prev_d});
      chk("ct_core_rvalid", bus.core_rvalid, {31'b0, (i > 0) && !prev_d});
      prev_d = exp_d;
      tick();
    end
    idle_reqs();
    #4;
    chk("ct_last_dma_rvalid", bus.dma_rvalid, 1);
    chk("ct_last_dma_rdata", bus.dma_rdata, 32'hA0000009);
    chk("ct_last_core_rdata", bus.core_rdata, 32'hA0000008);
    tick();

    // ---- DMA locked SW burst of 3 beats, core waiting ----
    $display("txn dma locked SW burst addr=020");
    bus.dma_req    = 1'b1;
    bus.dma_lock   = 1'b1;
    bus.dma_we     = 1'b1;
    bus.dma_addr   = 9'h020;
    bus.dma_wdata  = 32'hDEADBEEF;
    bus.dma_funct3 = F3_SW;
    #4;
    chk("lk_beat0_dma_gnt", bus.dma_gnt, 1);
    chk("lk_beat0_mem_write", bus.mem_write, 1);
    chk("lk_beat0_mem_wd", bus.mem_wd, 32'hDEADBEEF);
    chk("lk_beat0_mem_a", bus.mem_a, 32'h020);
    tick();
    bus.core_req    = 1'b1;
    bus.core_we     = 1'b0;
    bus.core_addr   = 9'h030;
    bus.core_funct3 = F3_LW;
    bus.mem_rd      = 32'h0BADF00D;
    for (int b = 1; b < 3; b++) begin
      #4;
      chk("lk_dma_gnt", bus.dma_gnt, 1);
      chk("lk_core_gnt", bus.core_gnt, 0);
      chk("lk_core_stall", bus.core_stall, 1);
      chk("lk_mem_write", bus.mem_write, 1);
      chk("lk_dma_rvalid", bus.dma_rvalid, 0);
      tick();
    end
    bus.dma_req  = 1'b0;
    bus.dma_lock = 1'b0;
    #4;
    chk("lk_end_core_gnt", bus.core_gnt, 1);
    chk("lk_end_dma_gnt", bus.dma_gnt, 0);
    chk("lk_end_core_stall", bus.core_stall, 0);
    chk("lk_end_mem_a", bus.mem_a, 32'h030);
    tick();
    idle_reqs();
    #4;
    chk("lk_core_rdata", bus.core_rdata, 32'h0BADF00D);
    tick();

    // ---- core SB then LBU at 0x004 ----
    $display("txn core SB addr=004 then LBU addr=004");
    bus.core_req    = 1'b1;
    bus.core_we     = 1'b1;
    bus.core_addr   = 9'h004;
    bus.core_wdata  = 32'h000000AB;
    bus.core_funct3 = F3_SB;
    #4;
    chk("sb_mem_write", bus.mem_write, 1);
    chk("sb_mem_read", bus.mem_read, 0);
    chk("sb_mem_funct3", bus.mem_funct3, 32'h0);
    chk("sb_mem_wd", bus.mem_wd, 32'hAB);
    tick();
    bus.core_we     = 1'b0;
    bus.core_funct3 = F3_LBU;
    bus.mem_rd      = 32'h000000AB;
    #4;
    chk("lbu_mem_read", bus.mem_read, 1);
    chk("lbu_mem_write", bus.mem_write, 0);
    chk("lbu_mem_funct3", bus.mem_funct3, 32'h4);
    chk("sb_no_rvalid", bus.core_rvalid, 0);
    tick();
    idle_reqs();
    bus.mem_rd = 32'h12345678;
    #4;
    chk("lbu_core_rvalid", bus.core_rvalid, 1);
    chk("lbu_core_rdata", bus.core_rdata, 32'hAB);
    tick();

    // ---- no requests: outputs idle, rdata holds ----
    $display("txn idle: no requests");
    for (int k = 0; k < 2; k++) begin
      #4;
      chk("id_mem_read", bus.mem_read, 0);
      chk("id_mem_write", bus.mem_write, 0);
      chk("id_core_gnt", bus.core_gnt, 0);
      chk("id_dma_gnt", bus.dma_gnt, 0);
      chk("id_mem_a", bus.mem_a, 0);
      chk("id_core_rdata", bus.core_rdata, 32'hAB);
      chk("id_dma_rdata", bus.dma_rdata, 32'hA0000009);
      tick();
    end

    // ---- reset in the cycle after a DMA load grant ----
    $display("txn dma LW addr=040 then reset");
    bus.dma_req    = 1'b1;
    bus.dma_we     = 1'b0;
    bus.dma_addr   = 9'h040;
    bus.dma_funct3 = F3_LW;
    bus.mem_rd     = 32'h55AA55AA;
    #4;
    chk("rs_dma_gnt", bus.dma_gnt, 1);
    chk("rs_mem_read", bus.mem_read, 1);
    tick();
    reset          = 1'b1;
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 9'h044;
    bus.dma_req    = 1'b1;
    bus.dma_we     = 1'b1;
    #4;
    chk("rs_dma_rvalid_in_rst", bus.dma_rvalid, 0);
    chk("rs_mem_write_in_rst", bus.mem_write, 0);
    tick();
    reset = 1'b0;
    idle_reqs();
    #4;
    chk("rs_dma_rvalid_after", bus.dma_rvalid, 0);
    chk("rs_dma_rdata_after", bus.dma_rdata, 0);
    chk("rs_state_after", dut.r_state, ST_IDLE);
    chk("rs_wait_cnt_after", dut.u_starve.r_cnt, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
